// File: rtl/nios_debug_ocimem_arbiter.sv
// Shares the Nios II OCI debug RAM between JTAG debug commands and the CPU
// debug-slave Avalon port, and keeps the JTAG-visible MonAReg/MonDReg/status.
module nios_debug_ocimem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_no_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic [AW-1:0] avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [DW-1:0] avs_writedata,
  output logic [DW-1:0] avs_readdata,
  output logic          avs_waitrequest,
  output logic [AW-1:0] ram_addr,
  output logic          ram_re,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW-1:0] MonAReg,
  output logic [DW-1:0] MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_RD,
    ST_JTAG_RD
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic          r_jtagPend;
  logic          r_jtagOpWr;
  logic          r_lastJtag;
  logic          r_monError;
  logic [AW-1:0] r_monAReg;
  logic [DW-1:0] r_monDReg;

  logic w_cpuReq;
  logic w_grantCpu;
  logic w_grantJtag;
  logic w_anyStrobe;
  logic w_multiStrobe;
  logic w_unusedJdo;

  assign w_cpuReq      = avs_read | avs_write;
  assign w_anyStrobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_multiStrobe = (take_action_ocimem_b & take_action_ocimem_a) |
                         (take_action_ocimem_b & take_no_action_ocimem_a) |
                         (take_action_ocimem_a & take_no_action_ocimem_a);
  assign w_unusedJdo   = ^{jdo[37:35], jdo[2:0]};

  // Grants are gated by reset_n so RAM strobes drop the instant reset asserts.
  always_comb begin
    w_grantCpu  = 1'b0;
    w_grantJtag = 1'b0;
    if (reset_n && (r_state == ST_IDLE)) begin
      if (w_cpuReq && r_jtagPend) begin
        w_grantCpu  = r_lastJtag;
        w_grantJtag = ~r_lastJtag;
      end else begin
        w_grantCpu  = w_cpuReq;
        w_grantJtag = r_jtagPend;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grantCpu && avs_read) begin
          w_nextState = ST_CPU_RD;
        end else if (w_grantJtag && !r_jtagOpWr) begin
          w_nextState = ST_JTAG_RD;
        end
      end
      ST_CPU_RD:  w_nextState = ST_IDLE;
      ST_JTAG_RD: w_nextState = ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  // A simultaneous read+write from the CPU is serviced as a read.
  always_comb begin
    ram_re          = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grantCpu) begin
          ram_addr = avs_address;
          if (avs_read) begin
            ram_re = 1'b1;
          end else begin
            ram_we          = 1'b1;
            ram_wdata       = avs_writedata;
            avs_waitrequest = 1'b0;
          end
        end else if (w_grantJtag) begin
          ram_addr = r_monAReg;
          if (r_jtagOpWr) begin
            ram_we    = 1'b1;
            ram_wdata = r_monDReg;
          end else begin
            ram_re = 1'b1;
          end
        end
      end
      ST_CPU_RD: begin
        avs_waitrequest = 1'b0;
        avs_readdata    = ram_rdata;
      end
      default: begin
      end
    endcase
  end

  // Strobes are only accepted with no op pending, so they never collide with
  // the completion updates of MonAReg/MonDReg/jtagPend in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_jtagPend <= 1'b0;
      r_jtagOpWr <= 1'b0;
      r_lastJtag <= 1'b0;
      r_monError <= 1'b0;
      r_monAReg  <= '0;
      r_monDReg  <= '0;
    end else begin
      if (w_grantCpu) begin
        r_lastJtag <= 1'b0;
      end else if (w_grantJtag) begin
        r_lastJtag <= 1'b1;
      end
      if (w_grantJtag && r_jtagOpWr) begin
        r_monAReg  <= r_monAReg + AW'(1);
        r_jtagPend <= 1'b0;
      end
      if (r_state == ST_JTAG_RD) begin
        r_monDReg  <= ram_rdata;
        r_jtagPend <= 1'b0;
      end
      if (w_anyStrobe) begin
        if (r_jtagPend) begin
          r_monError <= 1'b1;
        end else begin
          if (take_action_ocimem_b) begin
            r_monDReg  <= jdo[DW+2:3];
            r_jtagPend <= 1'b1;
            r_jtagOpWr <= 1'b1;
          end else if (take_action_ocimem_a) begin
            r_monAReg <= jdo[AW+2:3];
            if (jdo[17]) begin
              r_jtagPend <= 1'b1;
              r_jtagOpWr <= 1'b0;
            end
            if (jdo[24]) begin
              r_monError <= 1'b0;
            end
          end else begin
            r_monAReg  <= r_monAReg + AW'(1);
            r_jtagPend <= 1'b1;
            r_jtagOpWr <= 1'b0;
          end
          if (w_multiStrobe) begin
            r_monError <= 1'b1;
          end
        end
      end
    end
  end

  assign MonAReg       = r_monAReg;
  assign MonDReg       = r_monDReg;
  assign monitor_ready = ~r_jtagPend;
  assign monitor_error = r_monError;

endmodule
